// File: rtl/mfm_read.sv
// mfm_read: recovers MFM bit cells from the drive read pulses, locks byte
// alignment on the missing-clock A1 mark and writes decoded bytes (LSB-first)
// with a mark flag into the decode FIFO.
module mfm_read #(
   parameter int unsigned BIT_RATE_DIVISOR = 24,
   parameter logic [15:0] MARK_PATTERN     = 16'h4891
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       read_enable,
   input  logic       read_data_l,
   input  logic       decode_fifo_full,
   output logic [7:0] decode_fifo_wr_data,
   output logic       decode_fifo_wr_mark,
   output logic       decode_fifo_we,
   output logic       in_sync,
   output logic       overrun
);

   localparam int unsigned CW         = $clog2(BIT_RATE_DIVISOR);
   localparam logic [CW-1:0] CNT_FULL = CW'(BIT_RATE_DIVISOR - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(BIT_RATE_DIVISOR / 2 - 1);
   localparam logic [2:0] LOSS_RUN    = 3'd4;
   localparam logic [7:0] MARK_BYTE   = 8'hA1;

   typedef enum logic {HUNT, SYNC} state_t;

   state_t        state;
   logic [2:0]    sync_q;
   logic          re_q;
   logic [CW-1:0] cnt;
   logic          pulse_seen;
   logic [15:0]   sr;
   logic [2:0]    zero_run;
   logic          data_cell;
   logic [2:0]    bit_cnt;
   logic [7:0]    byte_q;

   logic          pulse;
   logic          cell_close;
   logic [15:0]   sr_next;
   logic [2:0]    zero_next;
   logic          mark_hit;
   logic          sync_lost;
   logic [7:0]    byte_next;
   logic          wr_req;
   logic [7:0]    wr_byte;
   logic          wr_mark;

   // Cell-close decode: next shift-register image, zero run and pending write
   always_comb begin
      pulse      = sync_q[2] & ~sync_q[1];
      cell_close = (cnt == '0);
      sr_next    = {sr[14:0], pulse_seen};
      zero_next  = pulse_seen ? 3'd0 : ((zero_run == LOSS_RUN) ? LOSS_RUN : zero_run + 3'd1);
      mark_hit   = cell_close && (sr_next == MARK_PATTERN);
      sync_lost  = (zero_next >= LOSS_RUN);
      byte_next  = {pulse_seen, byte_q[7:1]};
      wr_req     = 1'b0;
      wr_byte    = byte_next;
      wr_mark    = 1'b0;
      if (read_enable && cell_close) begin
         if (mark_hit) begin
            wr_req  = 1'b1;
            wr_byte = MARK_BYTE;
            wr_mark = 1'b1;
         end else if (state == SYNC && !sync_lost && data_cell && bit_cnt == 3'd7) begin
            wr_req  = 1'b1;
         end
      end
   end

   // Synchronizer, cell window, alignment FSM and registered FIFO write port
   always_ff @(posedge clk) begin
      if (reset) begin
         state               <= HUNT;
         sync_q              <= 3'b111;
         re_q                <= 1'b0;
         cnt                 <= CNT_FULL;
         pulse_seen          <= 1'b0;
         sr                  <= '0;
         zero_run            <= '0;
         data_cell           <= 1'b0;
         bit_cnt             <= '0;
         byte_q              <= '0;
         decode_fifo_wr_data <= '0;
         decode_fifo_wr_mark <= 1'b0;
         decode_fifo_we      <= 1'b0;
         in_sync             <= 1'b0;
         overrun             <= 1'b0;
      end else begin
         sync_q         <= {sync_q[1:0], read_data_l};
         re_q           <= read_enable;
         decode_fifo_we <= 1'b0;
         if (!read_enable) begin
            state      <= HUNT;
            cnt        <= CNT_FULL;
            pulse_seen <= 1'b0;
            sr         <= '0;
            zero_run   <= '0;
            data_cell  <= 1'b0;
            bit_cnt    <= '0;
            in_sync    <= 1'b0;
            if (re_q) overrun <= 1'b0;
         end else begin
            // a pulse re-centres the window; otherwise count down to the close
            if (pulse) begin
               pulse_seen <= 1'b1;
               cnt        <= CNT_HALF;
            end else if (cell_close) begin
               pulse_seen <= 1'b0;
               cnt        <= CNT_FULL;
            end else begin
               cnt <= cnt - CW'(1);
            end

            if (cell_close) begin
               sr       <= sr_next;
               zero_run <= zero_next;
               if (mark_hit) begin
                  state     <= SYNC;
                  in_sync   <= 1'b1;
                  data_cell <= 1'b0;
                  bit_cnt   <= '0;
               end else if (state == SYNC) begin
                  if (sync_lost) begin
                     state   <= HUNT;
                     in_sync <= 1'b0;
                  end else begin
                     data_cell <= ~data_cell;
                     if (data_cell) begin
                        byte_q  <= byte_next;
                        bit_cnt <= bit_cnt + 3'd1;
                     end
                  end
               end
            end

            if (wr_req) begin
               if (decode_fifo_full) begin
                  overrun <= 1'b1;
               end else begin
                  decode_fifo_we      <= 1'b1;
                  decode_fifo_wr_data <= wr_byte;
                  decode_fifo_wr_mark <= wr_mark;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_mfm_read.sv
// tb_mfm_read: directed bench for mfm_read; encodes bytes to MFM pulse trains
// and checks the decoded FIFO writes against hand-computed expectations.
module tb_mfm_read;

   localparam int unsigned DIV = 24;

   logic       clk = 1'b0;
   logic       reset;
   logic       read_enable;
   logic       read_data_l;
   logic       decode_fifo_full;
   logic [7:0] decode_fifo_wr_data;
   logic       decode_fifo_wr_mark;
   logic       decode_fifo_we;
   logic       in_sync;
   logic       overrun;

   int errors = 0;
   int checks = 0;
   int width_err = 0;
   logic we_prev = 1'b0;
   logic prev_bit = 1'b0;
   int jit = 0;
   logic [15:0] lfsr = 16'hACE1;
   logic [9:0] wq[$];   // {in_sync, mark, data} captured per strobe

   mfm_read dut (
      .clk                 (clk),
      .reset               (reset),
      .read_enable         (read_enable),
      .read_data_l         (read_data_l),
      .decode_fifo_full    (decode_fifo_full),
      .decode_fifo_wr_data (decode_fifo_wr_data),
      .decode_fifo_wr_mark (decode_fifo_wr_mark),
      .decode_fifo_we      (decode_fifo_we),
      .in_sync             (in_sync),
      .overrun             (overrun)
   );

   always #5 clk = ~clk;

   // Capture every write strobe and flag strobes longer than one clk
   always @(negedge clk) begin
      if (decode_fifo_we === 1'b1) begin
         wq.push_back({in_sync, decode_fifo_wr_mark, decode_fifo_wr_data});
         if (we_prev === 1'b1) width_err++;
      end
      we_prev = decode_fifo_we;
   end

   // Hard stop if something wedges
   initial begin
      #900_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [15:0] mfm_encode(input logic [7:0] b, input logic prev);
      logic [15:0] img;
      logic p;
      p = prev;
      img = '0;
      for (int i = 0; i < 8; i++) begin
         img[15 - 2*i] = ~p & ~b[i];
         img[14 - 2*i] = b[i];
         p = b[i];
      end
      return img;
   endfunction

   // One cell; a 1 cell gets a 2-clk low pulse mid-cell, optionally jittered
   task automatic send_cell(input logic b, input bit use_jit);
      int pos;
      pos = 12;
      if (b && use_jit) begin
         lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
         jit  = jit + int'(lfsr % 16'd13) - 6;
         if (jit > 8) jit = 8;
         if (jit < -8) jit = -8;
         pos = 12 + jit;
      end
      for (int c = 0; c < DIV; c++) begin
         read_data_l = !(b && (c == pos || c == pos + 1));
         @(negedge clk);
      end
      read_data_l = 1'b1;
   endtask

   task automatic send_image(input logic [15:0] img, input int n, input bit use_jit);
      for (int i = 0; i < n; i++) send_cell(img[15 - i], use_jit);
   endtask

   task automatic send_byte(input logic [7:0] b, input bit use_jit);
      send_image(mfm_encode(b, prev_bit), 16, use_jit);
      prev_bit = b[7];
   endtask

   task automatic send_mark(input bit use_jit);
      send_image(16'h4891, 16, use_jit);
      prev_bit = 1'b1;
   endtask

   task automatic send_preamble(input int n, input bit use_jit);
      for (int i = 0; i < n; i++) send_byte(8'h00, use_jit);
   endtask

   task automatic idle_cells(input int n);
      read_data_l = 1'b1;
      repeat (n * DIV) @(negedge clk);
      prev_bit = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1; read_enable = 1'b1; read_data_l = 1'b1; decode_fifo_full = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (decode_fifo_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b expected 0", decode_fifo_we); end
      checks++; if (decode_fifo_wr_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h expected 00", decode_fifo_wr_data); end
      checks++; if (decode_fifo_wr_mark !== 1'b0) begin errors++; $display("FAIL reset_mark got %b expected 0", decode_fifo_wr_mark); end
      checks++; if (in_sync !== 1'b0) begin errors++; $display("FAIL reset_in_sync got %b expected 0", in_sync); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b expected 0", overrun); end
      reset = 1'b0;
      idle_cells(10);
      checks++; if (wq.size() !== 0) begin errors++; $display("FAIL idle_no_write got %0d writes expected 0", wq.size()); end
      checks++; if (in_sync !== 1'b0) begin errors++; $display("FAIL idle_in_sync got %b expected 0", in_sync); end
   endtask

   task automatic run_stream(input bit use_jit, input string tag);
      logic [9:0] expv [3];
      logic [9:0] got;
      expv[0] = {1'b1, 1'b1, 8'hA1};
      expv[1] = {1'b1, 1'b0, 8'h5A};
      expv[2] = {1'b1, 1'b0, 8'hFF};
      wq.delete();
      jit = 0;
      send_preamble(12, use_jit);
      send_mark(use_jit);
      send_byte(8'h5A, use_jit);
      send_byte(8'hFF, use_jit);
      idle_cells(6);
      checks++; if (wq.size() !== 3) begin errors++; $display("FAIL %s_count got %0d expected 3", tag, wq.size()); end
      for (int i = 0; i < 3; i++) begin
         got = (wq.size() > i) ? wq[i] : 10'bx;
         checks++;
         if (got !== expv[i]) begin
            errors++;
            $display("FAIL %s_write%0d got sync/mark/data=%h expected %h", tag, i, got, expv[i]);
         end
      end
      checks++; if (width_err !== 0) begin errors++; $display("FAIL %s_strobe_width got %0d long strobes expected 0", tag, width_err); end
      checks++; if (in_sync !== 1'b0) begin errors++; $display("FAIL %s_in_sync_after got %b expected 0", tag, in_sync); end
   endtask

   task automatic test_sync_data;
      run_stream(1'b0, "sync_data");
   endtask

   task automatic test_jitter;
      run_stream(1'b1, "jitter");
   endtask

   task automatic test_sync_loss;
      logic [9:0] got;
      wq.delete();
      send_preamble(4, 1'b0);
      send_mark(1'b0);
      send_image(mfm_encode(8'h5A, 1'b1), 6, 1'b0);
      checks++; if (in_sync !== 1'b1) begin errors++; $display("FAIL loss_in_sync_before got %b expected 1", in_sync); end
      idle_cells(5);
      checks++; if (in_sync !== 1'b0) begin errors++; $display("FAIL loss_in_sync_after got %b expected 0", in_sync); end
      checks++; if (wq.size() !== 1) begin errors++; $display("FAIL loss_count got %0d expected 1", wq.size()); end
      // back in HUNT: preamble zeros must not be written, a new mark must be
      send_preamble(4, 1'b0);
      send_mark(1'b0);
      idle_cells(6);
      checks++; if (wq.size() !== 2) begin errors++; $display("FAIL resync_count got %0d expected 2", wq.size()); end
      got = (wq.size() > 1) ? wq[1] : 10'bx;
      checks++; if (got !== {1'b1, 1'b1, 8'hA1}) begin errors++; $display("FAIL resync_write got %h expected %h", got, {1'b1, 1'b1, 8'hA1}); end
   endtask

   task automatic test_full;
      logic [15:0] img;
      logic [9:0] got;
      wq.delete();
      send_preamble(4, 1'b0);
      send_mark(1'b0);
      img = mfm_encode(8'h5A, 1'b1);
      send_image(img, 1, 1'b0);
      decode_fifo_full = 1'b1;
      send_image(img << 1, 15, 1'b0);
      img = mfm_encode(8'hFF, 1'b0);
      send_image(img, 1, 1'b0);
      decode_fifo_full = 1'b0;
      send_image(img << 1, 15, 1'b0);
      prev_bit = 1'b1;
      idle_cells(6);
      checks++; if (wq.size() !== 2) begin errors++; $display("FAIL full_count got %0d expected 2", wq.size()); end
      got = (wq.size() > 0) ? wq[0] : 10'bx;
      checks++; if (got !== {1'b1, 1'b1, 8'hA1}) begin errors++; $display("FAIL full_mark got %h expected %h", got, {1'b1, 1'b1, 8'hA1}); end
      got = (wq.size() > 1) ? wq[1] : 10'bx;
      checks++; if (got !== {1'b1, 1'b0, 8'hFF}) begin errors++; $display("FAIL full_next_byte got %h expected %h", got, {1'b1, 1'b0, 8'hFF}); end
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL full_overrun got %b expected 1", overrun); end
      read_enable = 1'b0;
      @(negedge clk);
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_clear got %b expected 0", overrun); end
      read_enable = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_abort;
      logic [9:0] got;
      wq.delete();
      send_preamble(4, 1'b0);
      send_mark(1'b0);
      send_byte(8'h5A, 1'b0);
      send_image(mfm_encode(8'hFF, prev_bit), 8, 1'b0);
      checks++; if (in_sync !== 1'b1) begin errors++; $display("FAIL abort_in_sync_before got %b expected 1", in_sync); end
      read_enable = 1'b0;
      @(negedge clk);
      checks++; if (in_sync !== 1'b0) begin errors++; $display("FAIL abort_in_sync_next got %b expected 0", in_sync); end
      idle_cells(4);
      checks++; if (wq.size() !== 2) begin errors++; $display("FAIL abort_count got %0d expected 2", wq.size()); end
      got = (wq.size() > 1) ? wq[1] : 10'bx;
      checks++; if (got !== {1'b1, 1'b0, 8'h5A}) begin errors++; $display("FAIL abort_prior_byte got %h expected %h", got, {1'b1, 1'b0, 8'h5A}); end
      read_enable = 1'b1;
      send_preamble(4, 1'b0);
      send_mark(1'b0);
      idle_cells(6);
      checks++; if (wq.size() !== 3) begin errors++; $display("FAIL reenable_count got %0d expected 3", wq.size()); end
      got = (wq.size() > 2) ? wq[2] : 10'bx;
      checks++; if (got !== {1'b1, 1'b1, 8'hA1}) begin errors++; $display("FAIL reenable_mark got %h expected %h", got, {1'b1, 1'b1, 8'hA1}); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL abort_overrun got %b expected 0", overrun); end
   endtask

   initial begin
      test_reset();
      test_sync_data();
      test_jitter();
      test_sync_loss();
      test_full();
      test_abort();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
